// File: rtl/ucsbece154b_victim_ctrl_if.sv
// Bus bundle between the victim-cache miss controller and its surroundings:
// the L1 miss/refill handshakes, the victim cache port and the memory port.
// master = controller view, slave = view of the L1/victim-cache/memory side.
interface ucsbece154b_victim_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 56,
    parameter int unsigned LINE_WIDTH = 128
);
    // L1 miss request
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic                  evict_valid_i;
    logic [ADDR_WIDTH-1:0] evict_addr_i;
    logic [LINE_WIDTH-1:0] evict_data_i;
    // L1 refill response
    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [LINE_WIDTH-1:0] resp_data_o;
    logic                  resp_from_vc_o;
    // Victim cache port
    logic                  vc_en_o;
    logic [ADDR_WIDTH-1:0] vc_raddr_o;
    logic [LINE_WIDTH-1:0] vc_rdata_i;
    logic                  vc_hit_i;
    logic                  vc_we_o;
    logic [ADDR_WIDTH-1:0] vc_waddr_o;
    logic [LINE_WIDTH-1:0] vc_wdata_o;
    // Next-level memory port
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic [ADDR_WIDTH-1:0] mem_req_addr_o;
    logic                  mem_resp_valid_i;
    logic [LINE_WIDTH-1:0] mem_resp_data_i;
    // Performance counters
    logic [31:0]           hit_cnt_o;
    logic [31:0]           miss_cnt_o;

    modport master (
        input  req_valid_i, req_addr_i, evict_valid_i, evict_addr_i, evict_data_i,
        input  resp_ready_i, vc_rdata_i, vc_hit_i,
        input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_from_vc_o,
        output vc_en_o, vc_raddr_o, vc_we_o, vc_waddr_o, vc_wdata_o,
        output mem_req_valid_o, mem_req_addr_o, hit_cnt_o, miss_cnt_o
    );

    modport slave (
        output req_valid_i, req_addr_i, evict_valid_i, evict_addr_i, evict_data_i,
        output resp_ready_i, vc_rdata_i, vc_hit_i,
        output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_from_vc_o,
        input  vc_en_o, vc_raddr_o, vc_we_o, vc_waddr_o, vc_wdata_o,
        input  mem_req_valid_o, mem_req_addr_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/ucsbece154b_victim_ctrl.sv
// Victim cache miss controller: takes one L1 miss plus its evicted line,
// probes the victim cache, and refills from the victim cache or from memory.
// The evicted line is written into the victim cache during the probe cycle.
// Optional hit/miss counters are enabled with the macro VC_CTRL_PERF_CNT_EN.
module ucsbece154b_victim_ctrl #(
    parameter int unsigned ADDR_WIDTH = 56,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    ucsbece154b_victim_ctrl_if.master bus
);

    localparam int unsigned OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        ADDR_WIDTH'((64'd1 << OFFSET_WIDTH) - 64'd1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PROBE    = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  vc_we_q, vc_we_d;
    logic [ADDR_WIDTH-1:0] vc_waddr_q, vc_waddr_d;
    logic [LINE_WIDTH-1:0] vc_wdata_q, vc_wdata_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [LINE_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_from_vc_q, resp_from_vc_d;

    // Next state and next registered outputs; idle data outputs return to zero
    always_comb begin
        state_d         = state_q;
        req_ready_d     = 1'b0;
        req_addr_d      = req_addr_q;
        vc_we_d         = 1'b0;
        vc_waddr_d      = '0;
        vc_wdata_d      = '0;
        mem_req_valid_d = 1'b0;
        mem_req_addr_d  = '0;
        resp_valid_d    = 1'b0;
        resp_data_d     = '0;
        resp_from_vc_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid_i && req_ready_q) begin
                    state_d     = PROBE;
                    req_ready_d = 1'b0;
                    req_addr_d  = bus.req_addr_i;
                    if (bus.evict_valid_i) begin
                        vc_we_d    = 1'b1;
                        vc_waddr_d = bus.evict_addr_i;
                        vc_wdata_d = bus.evict_data_i;
                    end
                end
            end
            PROBE: begin
                if (bus.vc_hit_i) begin
                    state_d        = RESP;
                    resp_valid_d   = 1'b1;
                    resp_data_d    = bus.vc_rdata_i;
                    resp_from_vc_d = 1'b1;
                end else begin
                    state_d         = MEM_REQ;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = req_addr_q & ~OFFSET_MASK;
                end
            end
            MEM_REQ: begin
                mem_req_valid_d = 1'b1;
                mem_req_addr_d  = mem_req_addr_q;
                if (bus.mem_req_ready_i) begin
                    state_d         = MEM_WAIT;
                    mem_req_valid_d = 1'b0;
                    mem_req_addr_d  = '0;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_resp_valid_i) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = bus.mem_resp_data_i;
                end
            end
            RESP: begin
                resp_valid_d   = 1'b1;
                resp_data_d    = resp_data_q;
                resp_from_vc_d = resp_from_vc_q;
                if (bus.resp_ready_i) begin
                    state_d        = IDLE;
                    resp_valid_d   = 1'b0;
                    resp_data_d    = '0;
                    resp_from_vc_d = 1'b0;
                    req_ready_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any request in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b0;
            req_addr_q      <= '0;
            vc_we_q         <= 1'b0;
            vc_waddr_q      <= '0;
            vc_wdata_q      <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_from_vc_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            req_addr_q      <= req_addr_d;
            vc_we_q         <= vc_we_d;
            vc_waddr_q      <= vc_waddr_d;
            vc_wdata_q      <= vc_wdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_from_vc_q  <= resp_from_vc_d;
        end
    end

    assign bus.req_ready_o     = req_ready_q;
    assign bus.vc_raddr_o      = req_addr_q;
    assign bus.vc_we_o         = vc_we_q;
    assign bus.vc_waddr_o      = vc_waddr_q;
    assign bus.vc_wdata_o      = vc_wdata_q;
    assign bus.mem_req_valid_o = mem_req_valid_q;
    assign bus.mem_req_addr_o  = mem_req_addr_q;
    assign bus.resp_valid_o    = resp_valid_q;
    assign bus.resp_data_o     = resp_data_q;
    assign bus.resp_from_vc_o  = resp_from_vc_q;
    // Holding the victim cache disabled during reset invalidates its contents
    assign bus.vc_en_o         = ~rst_i;

`ifdef VC_CTRL_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating hit/miss counters, one event per probe cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == PROBE) begin
            if (bus.vc_hit_i) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign bus.hit_cnt_o  = hit_cnt_q;
    assign bus.miss_cnt_o = miss_cnt_q;
`else
    assign bus.hit_cnt_o  = '0;
    assign bus.miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ucsbece154b_victim_ctrl.sv
// Bench for the victim cache miss controller: a behavioural victim cache and
// memory surround the DUT, a transaction-level model predicts every refill.
module tb_ucsbece154b_victim_ctrl;

    localparam int unsigned AW  = 56;
    localparam int unsigned LW  = 128;
    localparam int unsigned NVC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst;

    ucsbece154b_victim_ctrl_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    ucsbece154b_victim_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
        return {a[AW-1:4], 4'h0};
    endfunction

    // ---------------- victim cache seen by the DUT ----------------
    logic          rv_vld  [NVC];
    logic [AW-1:0] rv_addr [NVC];
    logic [LW-1:0] rv_data [NVC];

    function automatic int rv_slot(input logic [AW-1:0] a);
        for (int i = 0; i < NVC; i++) if (rv_vld[i] && rv_addr[i] == a) return i;
        for (int i = 0; i < NVC; i++) if (!rv_vld[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!bus.vc_en_o) begin
            for (int i = 0; i < NVC; i++) rv_vld[i] <= 1'b0;
        end else if (bus.vc_we_o) begin
            rv_vld[rv_slot(line_of(bus.vc_waddr_o))]  <= 1'b1;
            rv_addr[rv_slot(line_of(bus.vc_waddr_o))] <= line_of(bus.vc_waddr_o);
            rv_data[rv_slot(line_of(bus.vc_waddr_o))] <= bus.vc_wdata_o;
        end
    end

    always_comb begin
        bus.vc_hit_i   = 1'b0;
        bus.vc_rdata_i = '0;
        for (int i = 0; i < NVC; i++) begin
            if (rv_vld[i] && rv_addr[i] == line_of(bus.vc_raddr_o)) begin
                bus.vc_hit_i   = 1'b1;
                bus.vc_rdata_i = rv_data[i];
            end
        end
    end

    // ---------------- transaction-level model ----------------
    logic          m_vld  [NVC];
    logic [AW-1:0] m_addr [NVC];
    logic [LW-1:0] m_line [NVC];
    logic [AW-1:0] m_req_addr = '0;
    logic          m_ev_valid = 1'b0;
    logic [AW-1:0] m_ev_addr  = '0;
    logic [LW-1:0] m_ev_data  = '0;
    logic          m_hit      = 1'b0;
    logic [LW-1:0] m_data     = '0;
    logic          m_busy     = 1'b0;
    logic [31:0]   m_hits     = '0;
    logic [31:0]   m_misses   = '0;

    function automatic logic model_lookup(input logic [AW-1:0] a, output logic [LW-1:0] d);
        d = '0;
        for (int i = 0; i < NVC; i++) begin
            if (m_vld[i] && m_addr[i] == line_of(a)) begin
                d = m_line[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [LW-1:0] d);
        int slot;
        slot = -1;
        for (int i = 0; i < NVC; i++) if (slot < 0 && m_vld[i] && m_addr[i] == line_of(a)) slot = i;
        for (int i = 0; i < NVC; i++) if (slot < 0 && !m_vld[i]) slot = i;
        m_vld[slot]  = 1'b1;
        m_addr[slot] = line_of(a);
        m_line[slot] = d;
    endtask

    task automatic reset_model();
        for (int i = 0; i < NVC; i++) m_vld[i] = 1'b0;
        m_req_addr = '0;
        m_ev_valid = 1'b0;
        m_busy     = 1'b0;
        m_hits     = '0;
        m_misses   = '0;
    endtask

    // Per-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        chk("vc_en", bus.vc_en_o, !rst);
        if (rst_q) begin
            chk("rst_req_ready", bus.req_ready_o, 0);
            chk("rst_resp_valid", bus.resp_valid_o, 0);
            chk("rst_mem_req_valid", bus.mem_req_valid_o, 0);
            chk("rst_vc_we", bus.vc_we_o, 0);
            chk("rst_resp_data", bus.resp_data_o, 0);
            chk("rst_mem_req_addr", bus.mem_req_addr_o, 0);
            chk("rst_vc_raddr", bus.vc_raddr_o, 0);
            chk("rst_hit_cnt", bus.hit_cnt_o, 0);
            chk("rst_miss_cnt", bus.miss_cnt_o, 0);
        end else begin
            chk("vc_raddr", bus.vc_raddr_o, m_req_addr);
            chk("ready_and_resp", bus.req_ready_o & bus.resp_valid_o, 0);
            chk("stray_resp", bus.resp_valid_o & ~m_busy, 0);
            if (bus.resp_valid_o) begin
                chk("resp_data", bus.resp_data_o, m_data);
                chk("resp_from_vc", bus.resp_from_vc_o, m_hit);
            end else begin
                chk("resp_data_idle", bus.resp_data_o, 0);
                chk("resp_from_vc_idle", bus.resp_from_vc_o, 0);
            end
            chk("mem_req_on_hit", bus.mem_req_valid_o & m_hit, 0);
            if (bus.mem_req_valid_o)
                chk("mem_req_addr", bus.mem_req_addr_o, line_of(m_req_addr));
            else
                chk("mem_req_addr_idle", bus.mem_req_addr_o, 0);
            chk("we_without_evict", bus.vc_we_o & ~m_ev_valid, 0);
            if (bus.vc_we_o) begin
                chk("vc_waddr", bus.vc_waddr_o, m_ev_addr);
                chk("vc_wdata", bus.vc_wdata_o, m_ev_data);
            end else begin
                chk("vc_waddr_idle", bus.vc_waddr_o, 0);
                chk("vc_wdata_idle", bus.vc_wdata_o, 0);
            end
        end
    end

    task automatic check_counters();
`ifdef VC_CTRL_PERF_CNT_EN
        chk("hit_cnt", bus.hit_cnt_o, m_hits);
        chk("miss_cnt", bus.miss_cnt_o, m_misses);
`else
        chk("hit_cnt_tied", bus.hit_cnt_o, 0);
        chk("miss_cnt_tied", bus.miss_cnt_o, 0);
`endif
    endtask

    // Reset for n cycles; entered and left at posedge+1
    task automatic do_reset(input int n);
        rst = 1'b1;
        @(posedge clk); #1;
        reset_model();
        chk("vc_en_in_reset", bus.vc_en_o, 0);
        repeat (n - 1) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", bus.req_ready_o, 1);
    endtask

    // One miss request; cycle 0 is the request handshake cycle
    task automatic do_req(
        input  logic [AW-1:0] addr,
        input  logic          ev_v,
        input  logic [AW-1:0] ev_a,
        input  logic [LW-1:0] ev_d,
        input  logic [LW-1:0] mem_d,
        input  int            mem_stall,
        input  int            resp_stall,
        input  bit            abort,
        output int            mem_cyc,
        output int            resp_cyc,
        output logic [AW-1:0] mem_addr_seen,
        output logic [LW-1:0] resp_seen,
        output logic          from_vc_seen
    );
        int   c, ms, rs, mresp_at;
        bit   done;
        logic [LW-1:0] vd;
        c = 0;
        while (!bus.req_ready_o && c < 20) begin @(posedge clk); #1; c++; end
        chk("req_ready_wait", bus.req_ready_o, 1);
        bus.req_valid_i   = 1'b1;
        bus.req_addr_i    = addr;
        bus.evict_valid_i = ev_v;
        bus.evict_addr_i  = ev_a;
        bus.evict_data_i  = ev_d;
        @(posedge clk); #1;
        bus.req_valid_i   = 1'b0;
        bus.evict_valid_i = 1'b0;
        // model: decide hit on contents before this request's eviction
        m_hit      = model_lookup(addr, vd);
        m_data     = m_hit ? vd : mem_d;
        m_req_addr = addr;
        m_ev_valid = ev_v;
        m_ev_addr  = ev_v ? ev_a : '0;
        m_ev_data  = ev_v ? ev_d : '0;
        if (ev_v) model_write(ev_a, ev_d);
        if (m_hit) begin if (m_hits != 32'hFFFF_FFFF) m_hits++; end
        else begin if (m_misses != 32'hFFFF_FFFF) m_misses++; end
        m_busy = 1'b1;

        c = 1; ms = 0; rs = 0; mresp_at = -1; done = 0;
        mem_cyc = -1; resp_cyc = -1; mem_addr_seen = '0; resp_seen = '0; from_vc_seen = 1'b0;
        while (!done && c < 80) begin
            bus.mem_resp_valid_i = (c == mresp_at);
            bus.mem_resp_data_i  = (c == mresp_at) ? mem_d : '0;
            bus.mem_req_ready_i  = 1'b0;
            bus.resp_ready_i     = 1'b0;
            if (abort && mresp_at >= 0 && c == mresp_at - 1) begin
                rst = 1'b1;
                return;
            end
            if (bus.mem_req_valid_o) begin
                if (mem_cyc < 0) begin
                    mem_cyc = c;
                    mem_addr_seen = bus.mem_req_addr_o;
                end else begin
                    chk("mem_addr_stable", bus.mem_req_addr_o, mem_addr_seen);
                end
                if (ms < mem_stall) ms++;
                else begin
                    bus.mem_req_ready_i = 1'b1;
                    mresp_at = c + 2;
                end
            end
            if (bus.resp_valid_o) begin
                if (resp_cyc < 0) begin
                    resp_cyc = c;
                    resp_seen = bus.resp_data_o;
                    from_vc_seen = bus.resp_from_vc_o;
                end else begin
                    chk("resp_data_stable", bus.resp_data_o, resp_seen);
                end
                chk("req_ready_in_resp", bus.req_ready_o, 0);
                if (rs < resp_stall) rs++;
                else begin
                    bus.resp_ready_i = 1'b1;
                    done = 1;
                end
            end
            @(posedge clk); #1;
            c++;
        end
        bus.resp_ready_i     = 1'b0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_resp_data_i  = '0;
        chk("tx_complete", done, 1);
        m_busy     = 1'b0;
        m_ev_valid = 1'b0;
        chk("ready_after_resp", bus.req_ready_o, 1);
        check_counters();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            mc, rc;
        logic [AW-1:0] ma;
        logic [LW-1:0] rd;
        logic          fv;
        logic [LW-1:0] line_aa, line_55, line_66, line_3c;
        line_aa = {16{8'hAA}};
        line_55 = {16{8'h55}};
        line_66 = {16{8'h66}};
        line_3c = {16{8'h3C}};
        bus.req_valid_i      = 1'b0;
        bus.req_addr_i       = '0;
        bus.evict_valid_i    = 1'b0;
        bus.evict_addr_i     = '0;
        bus.evict_data_i     = '0;
        bus.resp_ready_i     = 1'b0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_resp_data_i  = '0;
        do_reset(3);
        check_counters();

        // cold miss, no eviction
        do_req(56'h1234, 1'b0, '0, '0, line_aa, 0, 0, 1'b0, mc, rc, ma, rd, fv);
        chk("cold_mem_cycle", mc, 2);
        chk("cold_mem_addr", ma, 56'h1230);
        chk("cold_resp_cycle", rc, 5);
        chk("cold_data", rd, line_aa);
        chk("cold_from_vc", fv, 0);
`ifdef VC_CTRL_PERF_CNT_EN
        chk("cold_miss_cnt", bus.miss_cnt_o, 1);
`endif

        // miss that evicts line 0x200, then hits on it back-to-back
        do_req(56'h100, 1'b1, 56'h200, line_55, {16{8'h11}}, 0, 0, 1'b0, mc, rc, ma, rd, fv);
        chk("evict_miss_data", rd, {16{8'h11}});
        do_req(56'h200, 1'b0, '0, '0, {16{8'hEE}}, 0, 0, 1'b0, mc, rc, ma, rd, fv);
        chk("hit_resp_cycle", rc, 2);
        chk("hit_no_mem", mc, -1);
        chk("hit_data", rd, line_55);
        chk("hit_from_vc", fv, 1);
        // unaligned address in the same line
        do_req(56'h208, 1'b0, '0, '0, {16{8'hEE}}, 0, 0, 1'b0, mc, rc, ma, rd, fv);
        chk("hit_unaligned_data", rd, line_55);
        // evicting the requested line: old contents served, new one written
        do_req(56'h200, 1'b1, 56'h200, line_66, {16{8'hEE}}, 0, 0, 1'b0, mc, rc, ma, rd, fv);
        chk("self_evict_old", rd, line_55);
        do_req(56'h200, 1'b0, '0, '0, {16{8'hEE}}, 0, 0, 1'b0, mc, rc, ma, rd, fv);
        chk("self_evict_new", rd, line_66);

        // backpressure on both memory request and refill response
        do_req(56'h4567, 1'b1, 56'h300, {16{8'h77}}, line_3c, 5, 4, 1'b0, mc, rc, ma, rd, fv);
        chk("bp_mem_cycle", mc, 2);
        chk("bp_mem_addr", ma, 56'h4560);
        chk("bp_resp_cycle", rc, 10);
        chk("bp_data", rd, line_3c);

        // stray memory data while idle
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = {16{8'h99}};
        @(posedge clk); #1;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_resp_data_i  = '0;
        chk("stray_no_resp", bus.resp_valid_o, 0);
        chk("stray_still_idle", bus.req_ready_o, 1);
        @(posedge clk); #1;
        chk("stray_no_resp2", bus.resp_valid_o, 0);

        // reset while waiting on memory
        do_req(56'h5000, 1'b1, 56'h600, {16{8'h42}}, {16{8'hDD}}, 0, 0, 1'b1, mc, rc, ma, rd, fv);
        do_reset(2);
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = {16{8'hDD}};
        @(posedge clk); #1;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_resp_data_i  = '0;
        chk("late_mem_no_resp", bus.resp_valid_o, 0);
        check_counters();
        do_req(56'h600, 1'b0, '0, '0, {16{8'hC3}}, 0, 0, 1'b0, mc, rc, ma, rd, fv);
        chk("post_reset_miss", fv, 0);
        chk("post_reset_data", rd, {16{8'hC3}});

`ifdef VC_CTRL_PERF_CNT_EN
        // saturation of the miss counter
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.miss_cnt_q;
        m_misses = 32'hFFFF_FFFF;
        do_req(56'h7000, 1'b0, '0, '0, {16{8'h0F}}, 0, 0, 1'b0, mc, rc, ma, rd, fv);
        chk("miss_cnt_sat", bus.miss_cnt_o, 32'hFFFF_FFFF);
`endif

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
